// File: rtl/pru_pkg.sv
// Shared definitions for the pixel render unit command queue: register map,
// command entry layout and sequencer states.
package pru_pkg;

  localparam logic [31:0] AddrGeom    = 32'h4000_0100;
  localparam logic [31:0] AddrSize    = 32'h4000_0104;
  localparam logic [31:0] AddrBmap    = 32'h4000_0108;
  localparam logic [31:0] AddrCmd     = 32'h4000_0120;
  localparam logic [31:0] AddrStatus  = 32'h4000_0124;
  localparam logic [31:0] AddrDoneCnt = 32'h4000_0128;

  typedef enum logic [1:0] {
    ShapeRect   = 2'b00,
    ShapeCircle = 2'b01,
    ShapeBitmap = 2'b10,
    ShapeLetter = 2'b11
  } shape_e;

  // 74-bit queued draw command
  typedef struct packed {
    logic [9:0]  col;
    logic [8:0]  row;
    logic [9:0]  width;
    logic [8:0]  height_radius;
    logic [31:0] bitmap_addr;
    shape_e      shape;
    logic [1:0]  color;
  } pru_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRelease
  } seq_state_e;

endpackage

// File: rtl/pru_cmd_fifo.sv
// Synchronous FIFO with flush; flush wins over push and pop in the same cycle.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module pru_cmd_fifo #(
  parameter int unsigned Depth = 8,
  parameter type entry_t = logic,
  localparam int unsigned AW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  entry_t          data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output entry_t          data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  entry_t          mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pru_cmd_queue.sv
// MMIO command queue for the pixel render unit: staging registers, a command
// FIFO and a sequencer that hands one command at a time to the render unit.
module pru_cmd_queue
  import pru_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  input  logic        bus_we_i,
  input  logic        bus_re_i,
  output logic [31:0] bus_rdata_o,
  input  logic        pru_busy_i,
  input  logic        pru_done_i,
  output logic        pru_start_o,
  output logic [1:0]  pru_shape_select_o,
  output logic [1:0]  pru_color_o,
  output logic [9:0]  pru_col_o,
  output logic [8:0]  pru_row_o,
  output logic [9:0]  pru_width_o,
  output logic [8:0]  pru_height_radius_o,
  output logic [31:0] pru_bitmap_addr_o,
  output logic        irq_done_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [9:0]  geom_col_q, size_w_q;
  logic [8:0]  geom_row_q, size_h_q;
  logic [31:0] bmap_q, rdata_q, rdata_d;
  logic [15:0] done_cnt_q;
  logic        ovf_q, start_q, irq_q;
  seq_state_e  state_q;
  pru_cmd_t    cmd_q, new_entry, fifo_head;

  logic            cmd_wr, cmd_push, cmd_flush, fifo_pop, push_drop, done_evt;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [4:0]      status_cnt;
  logic            unused_busy;

  // The render unit handshake is fully covered by start/done.
  assign unused_busy = pru_busy_i;

  assign cmd_wr     = bus_we_i && (bus_addr_i == AddrCmd);
  assign cmd_push   = cmd_wr && !bus_wdata_i[31];
  assign cmd_flush  = cmd_wr && bus_wdata_i[31];
  assign fifo_pop   = (state_q == StIssue);
  assign push_drop  = cmd_push && fifo_full && !(fifo_pop && !fifo_empty);
  assign done_evt   = (state_q == StRelease) && !pru_done_i;
  assign status_cnt = 5'(fifo_count);

  assign new_entry = '{col: geom_col_q, row: geom_row_q, width: size_w_q,
                       height_radius: size_h_q, bitmap_addr: bmap_q,
                       shape: shape_e'(bus_wdata_i[1:0]), color: bus_wdata_i[3:2]};

  pru_cmd_fifo #(
    .Depth   (DEPTH),
    .entry_t (pru_cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_push),
    .data_i  (new_entry),
    .pop_i   (fifo_pop),
    .flush_i (cmd_flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rdata_d = '0;
    case (bus_addr_i)
      AddrStatus:  rdata_d = {23'b0, ovf_q, status_cnt, fifo_empty, fifo_full,
                              state_q != StIdle};
      AddrDoneCnt: rdata_d = {16'b0, done_cnt_q};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      geom_col_q <= '0;
      geom_row_q <= '0;
      size_w_q   <= '0;
      size_h_q   <= '0;
      bmap_q     <= '0;
      ovf_q      <= 1'b0;
      done_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      if (bus_we_i && bus_addr_i == AddrGeom) begin
        geom_col_q <= bus_wdata_i[9:0];
        geom_row_q <= bus_wdata_i[24:16];
      end
      if (bus_we_i && bus_addr_i == AddrSize) begin
        size_w_q <= bus_wdata_i[9:0];
        size_h_q <= bus_wdata_i[24:16];
      end
      if (bus_we_i && bus_addr_i == AddrBmap) bmap_q <= bus_wdata_i;
      if (bus_we_i && bus_addr_i == AddrStatus) ovf_q <= 1'b0;
      else if (push_drop)                       ovf_q <= 1'b1;
      if (bus_we_i && bus_addr_i == AddrDoneCnt) done_cnt_q <= '0;
      else if (done_evt)                         done_cnt_q <= done_cnt_q + 16'd1;
      if (bus_re_i) rdata_q <= rdata_d;
    end
  end

  // Sequencer; a flush racing the IDLE->ISSUE step can leave nothing to pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        StIdle: if (!fifo_empty) state_q <= StIssue;
        StIssue: begin
          if (fifo_empty) begin
            state_q <= StIdle;
          end else begin
            cmd_q   <= fifo_head;
            start_q <= 1'b1;
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (pru_done_i) begin
            start_q <= 1'b0;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          if (!pru_done_i) begin
            irq_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_rdata_o         = rdata_q;
  assign pru_start_o         = start_q;
  assign irq_done_o          = irq_q;
  assign pru_shape_select_o  = cmd_q.shape;
  assign pru_color_o         = cmd_q.color;
  assign pru_col_o           = cmd_q.col;
  assign pru_row_o           = cmd_q.row;
  assign pru_width_o         = cmd_q.width;
  assign pru_height_radius_o = cmd_q.height_radius;
  assign pru_bitmap_addr_o   = cmd_q.bitmap_addr;

endmodule

// File: tb/tb_pru_cmd_queue.sv
// Scoreboard bench: expected commands are queued at CMD writes and compared
// when the queue raises pru_start; a small render-unit model answers with done.
module tb_pru_cmd_queue;
  import pru_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic        bus_we = 1'b0, bus_re = 1'b0;
  logic        pru_busy = 1'b0, pru_done = 1'b0;
  logic [31:0] bus_rdata, pru_bitmap_addr;
  logic        pru_start, irq_done;
  logic [1:0]  pru_shape_select, pru_color;
  logic [9:0]  pru_col, pru_width;
  logic [8:0]  pru_row, pru_height_radius;
  logic [73:0] obs;

  always #5 clk = ~clk;

  pru_cmd_queue #(.DEPTH(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .bus_addr_i          (bus_addr),
    .bus_wdata_i         (bus_wdata),
    .bus_we_i            (bus_we),
    .bus_re_i            (bus_re),
    .bus_rdata_o         (bus_rdata),
    .pru_busy_i          (pru_busy),
    .pru_done_i          (pru_done),
    .pru_start_o         (pru_start),
    .pru_shape_select_o  (pru_shape_select),
    .pru_color_o         (pru_color),
    .pru_col_o           (pru_col),
    .pru_row_o           (pru_row),
    .pru_width_o         (pru_width),
    .pru_height_radius_o (pru_height_radius),
    .pru_bitmap_addr_o   (pru_bitmap_addr),
    .irq_done_o          (irq_done)
  );

  assign obs = {pru_col, pru_row, pru_width, pru_height_radius, pru_bitmap_addr,
                pru_shape_select, pru_color};

  int       checks = 0, errors = 0;
  int       irq_cnt = 0, start_cnt = 0, wait_cnt = 0;
  bit       busy_seen = 1'b0, stall = 1'b0;
  pru_cmd_t sb[$];
  pru_cmd_t cur;

  task automatic check(input string tag, input logic [73:0] got, input logic [73:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic pru_cmd_t mk(input logic [31:0] geom, input logic [31:0] size,
                                  input logic [31:0] bmap, input logic [3:0] cmd);
    pru_cmd_t c;
    c.col           = geom[9:0];
    c.row           = geom[24:16];
    c.width         = size[9:0];
    c.height_radius = size[24:16];
    c.bitmap_addr   = bmap;
    c.shape         = shape_e'(cmd[1:0]);
    c.color         = cmd[3:2];
    return c;
  endfunction

  // Render unit model: done pulses 10 unstalled cycles after start is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_seen = 1'b0;
      pru_done  = 1'b0;
      pru_busy  = 1'b0;
    end else begin
      if (irq_done) irq_cnt++;
      if (pru_done) begin
        pru_done = 1'b0;
      end else if (pru_start && !busy_seen) begin
        busy_seen = 1'b1;
        pru_busy  = 1'b1;
        start_cnt++;
        wait_cnt  = 10;
        check("sb_nonempty_at_start", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("cmd_fields", obs, cur);
        end
      end else if (pru_start && !stall) begin
        wait_cnt--;
        if (wait_cnt <= 0) begin
          check("cmd_stable", obs, cur);
          pru_done = 1'b1;
          pru_busy = 1'b0;
        end
      end else if (!pru_start) begin
        busy_seen = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic wait_irq(input int target, input int bound);
    for (int i = 0; i < bound && irq_cnt < target; i++) @(negedge clk);
    check("irq_count", irq_cnt, target);
  endtask

  logic [31:0] rd, geom, size, bmap;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and unmapped/write-only reads
    check("rst_start", pru_start, 0);
    check("rst_irq", irq_done, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_outputs", obs, 0);
    bus_read(AddrStatus, rd);  check("rst_status", rd, 32'h4);
    bus_read(AddrDoneCnt, rd); check("rst_done_cnt", rd, 0);
    bus_write(32'h4000_010C, 32'hFFFF_FFFF);
    bus_read(AddrStatus, rd);  check("palette_status", rd, 32'h4);
    bus_read(AddrGeom, rd);    check("geom_reads_zero", rd, 0);

    // Single command with exact start latency
    geom = 32'h0032_0064; size = 32'h0014_0028; bmap = '0;
    bus_write(AddrGeom, geom);
    bus_write(AddrSize, size);
    sb.push_back(mk(geom, size, bmap, 4'h5));
    bus_write(AddrCmd, 32'h5);
    @(negedge clk); check("start_low_1st_edge", pru_start, 0);
    @(negedge clk); check("start_high_2nd_edge", pru_start, 1);
    wait_irq(1, 40);
    repeat (5) @(negedge clk);
    check("irq_single_pulse", irq_cnt, 1);
    bus_read(AddrDoneCnt, rd); check("done_cnt_1", rd, 1);
    bus_read(AddrStatus, rd);  check("idle_status", rd, 32'h4);

    // Overflow with the render unit stalled: 1 in flight, 8 queued, 1 dropped
    stall = 1'b1;
    bmap = 32'h1000_0000;
    bus_write(AddrBmap, bmap);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(mk(geom, size, bmap, 4'(i)));
      bus_write(AddrCmd, 32'(i));
    end
    bus_read(AddrStatus, rd);  check("ovf_status", rd, 32'h143);
    bus_write(AddrStatus, 32'h0);
    bus_read(AddrStatus, rd);  check("ovf_cleared", rd, 32'h043);
    bus_read(AddrDoneCnt, rd); check("ovf_done_cnt", rd, 1);

    // Push lands on the pop edge while full
    stall = 1'b0;
    for (int i = 0; i < 40 && !irq_done; i++) @(negedge clk);
    check("irq_before_pushpop", irq_done, 1);
    stall = 1'b1;
    @(negedge clk);
    sb.push_back(mk(geom, size, bmap, 4'hA));
    bus_write(AddrCmd, 32'hA);
    bus_read(AddrStatus, rd);  check("pushpop_status", rd, 32'h043);

    // Flush while one command is in flight
    bus_write(AddrCmd, 32'h8000_0000);
    sb.delete();
    bus_read(AddrStatus, rd);  check("flush_status", rd, 32'h5);
    stall = 1'b0;
    wait_irq(3, 40);
    repeat (20) @(negedge clk);
    check("flush_no_new_starts", start_cnt, 3);
    bus_read(AddrStatus, rd);  check("flush_idle_status", rd, 32'h4);
    bus_read(AddrDoneCnt, rd); check("flush_done_cnt", rd, 3);

    // Queue drain in FIFO order
    bus_write(AddrDoneCnt, 32'h0);
    bus_read(AddrDoneCnt, rd); check("done_cnt_clear", rd, 0);
    for (int k = 0; k < 3; k++) begin
      geom = 32'(k + 1) * 32'h0001_0010;
      bmap = 32'hB000_0000 + 32'(k);
      bus_write(AddrGeom, geom);
      bus_write(AddrBmap, bmap);
      sb.push_back(mk(geom, size, bmap, 4'(k * 5)));
      bus_write(AddrCmd, 32'(k * 5));
    end
    wait_irq(6, 150);
    check("drain_starts", start_cnt, 6);
    check("drain_sb_empty", sb.size(), 0);
    bus_read(AddrDoneCnt, rd); check("drain_done_cnt", rd, 3);

    // Reset during WAIT_DONE
    stall = 1'b1;
    sb.push_back(mk(geom, size, bmap, 4'h7));
    bus_write(AddrCmd, 32'h7);
    for (int i = 0; i < 20 && !pru_start; i++) @(negedge clk);
    check("reset_test_started", pru_start, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_start_low", pru_start, 0);
    check("reset_outputs_zero", obs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    stall = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_no_irq", irq_cnt, 6);
    check("reset_no_restart", start_cnt, 7);
    bus_read(AddrStatus, rd);  check("reset_status", rd, 32'h4);
    bus_read(AddrDoneCnt, rd); check("reset_done_cnt", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
